clic_irq_tx: RTL and testbench

- CLIC-side transmitter that drives the core's CLIC interrupt input port: valid/id/level/priv/shv, with ready and kill handshakes.
- Sequentially scans the per-source pending/enable/level/priv/shv vectors, selects the highest-level eligible source above threshold, offers it to the core and holds the offer until the core accepts it or a kill completes.
- Sits between the CLIC register file and the CVA6 core in CLIC-enabled configurations.

---
 rtl/clic_irq_tx.sv | 203 ++++++++++++++++++++
 tb/tb_clic_irq_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clic_irq_tx.sv
// CLIC interrupt transmitter: chunked scan for the highest-level eligible source, offered to the core
// with ready/kill handshakes. Optional preemption of a pending offer is enabled by CLIC_IRQ_TX_PREEMPT_EN.
module clic_irq_tx #(
  parameter int NumSrc = 256,
  parameter int Lanes  = 16,
  parameter int LvlW   = 8,
  parameter int IdW    = $clog2(NumSrc)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumSrc-1:0]      ip_i,
  input  logic [NumSrc-1:0]      ie_i,
  input  logic [NumSrc*LvlW-1:0] lvl_i,
  input  logic [NumSrc*2-1:0]    priv_i,
  input  logic [NumSrc-1:0]      shv_i,
  input  logic [LvlW-1:0]        thresh_i,
  output logic                   irq_valid_o,
  output logic [IdW-1:0]         irq_id_o,
  output logic [LvlW-1:0]        irq_level_o,
  output logic [1:0]             irq_priv_o,
  output logic                   irq_shv_o,
  input  logic                   irq_ready_i,
  output logic                   irq_kill_req_o,
  input  logic                   irq_kill_ack_i,
  output logic                   claim_o,
  output logic [IdW-1:0]         claim_id_o
);

  localparam int Chunks = NumSrc / Lanes;
  localparam int IdxW   = (Chunks > 1) ? $clog2(Chunks) : 1;

  typedef enum logic [1:0] {IDLE, OFFER, KILL} state_e;
  state_e state_q, state_d;

  logic [IdxW-1:0] idx_q;
  logic            best_vld, cand_vld;
  logic [LvlW-1:0] best_lvl, cand_lvl;
  logic [IdW-1:0]  best_id, cand_id;
  logic [1:0]      best_priv, cand_priv;
  logic            best_shv, cand_shv;

  logic            c_vld;
  logic [LvlW-1:0] c_lvl;
  logic [IdW-1:0]  c_id;
  logic [1:0]      c_priv;
  logic            c_shv;
  logic [IdW-1:0]  s;

  // Chunk winner: strictly-greater compare in ascending id order keeps ties on the lowest id.
  always_comb begin
    c_vld  = 1'b0;
    c_lvl  = '0;
    c_id   = '0;
    c_priv = '0;
    c_shv  = 1'b0;
    s      = '0;
    for (int l = 0; l < Lanes; l++) begin
      s = IdW'(int'(idx_q) * Lanes + l);
      if (ip_i[s] && ie_i[s] && (lvl_i[s*LvlW +: LvlW] != '0) && (lvl_i[s*LvlW +: LvlW] > c_lvl)) begin
        c_vld  = 1'b1;
        c_lvl  = lvl_i[s*LvlW +: LvlW];
        c_id   = s;
        c_priv = priv_i[s*2 +: 2];
        c_shv  = shv_i[s];
      end
    end
  end

  logic            take, last_chunk;
  logic            m_vld, m_shv;
  logic [LvlW-1:0] m_lvl;
  logic [IdW-1:0]  m_id;
  logic [1:0]      m_priv;

  assign take       = c_lvl > best_lvl;
  assign last_chunk = (idx_q == IdxW'(Chunks - 1));
  assign m_vld      = best_vld | c_vld;
  assign m_lvl      = take ? c_lvl  : best_lvl;
  assign m_id       = take ? c_id   : best_id;
  assign m_priv     = take ? c_priv : best_priv;
  assign m_shv      = take ? c_shv  : best_shv;

  logic src_live, kill_cond;
  logic load, accept, kill_go, drop, restart;

  assign src_live = ip_i[irq_id_o] & ie_i[irq_id_o];
`ifdef CLIC_IRQ_TX_PREEMPT_EN
  assign kill_cond = !src_live || (cand_vld && (cand_lvl > irq_level_o));
`else
  assign kill_cond = !src_live;
`endif
  assign restart = accept | drop;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    accept  = 1'b0;
    kill_go = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cand_vld && (cand_lvl > thresh_i)) begin
          load    = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (irq_ready_i) begin
          accept  = 1'b1;
          state_d = IDLE;
        end else if (kill_cond) begin
          kill_go = 1'b1;
          state_d = KILL;
        end
      end
      KILL: begin
        if (irq_ready_i) begin
          accept  = 1'b1;
          state_d = IDLE;
        end else if (irq_kill_ack_i) begin
          drop    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A restart discards both the running best and the latched candidate so a claimed or
  // killed source is never re-offered from stale scan data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      best_vld  <= 1'b0;
      best_lvl  <= '0;
      best_id   <= '0;
      best_priv <= '0;
      best_shv  <= 1'b0;
      cand_vld  <= 1'b0;
      cand_lvl  <= '0;
      cand_id   <= '0;
      cand_priv <= '0;
      cand_shv  <= 1'b0;
    end else if (restart || last_chunk) begin
      idx_q     <= '0;
      best_vld  <= 1'b0;
      best_lvl  <= '0;
      best_id   <= '0;
      best_priv <= '0;
      best_shv  <= 1'b0;
      cand_vld  <= restart ? 1'b0 : m_vld;
      cand_lvl  <= restart ? '0   : m_lvl;
      cand_id   <= restart ? '0   : m_id;
      cand_priv <= restart ? '0   : m_priv;
      cand_shv  <= restart ? 1'b0 : m_shv;
    end else begin
      idx_q     <= idx_q + IdxW'(1);
      best_vld  <= m_vld;
      best_lvl  <= m_lvl;
      best_id   <= m_id;
      best_priv <= m_priv;
      best_shv  <= m_shv;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_valid_o    <= 1'b0;
      irq_id_o       <= '0;
      irq_level_o    <= '0;
      irq_priv_o     <= '0;
      irq_shv_o      <= 1'b0;
      irq_kill_req_o <= 1'b0;
      claim_o        <= 1'b0;
      claim_id_o     <= '0;
    end else begin
      claim_o    <= accept;
      claim_id_o <= accept ? irq_id_o : '0;
      if (load) begin
        irq_valid_o <= 1'b1;
        irq_id_o    <= cand_id;
        irq_level_o <= cand_lvl;
        irq_priv_o  <= cand_priv;
        irq_shv_o   <= cand_shv;
      end else if (restart) begin
        irq_valid_o    <= 1'b0;
        irq_kill_req_o <= 1'b0;
        irq_id_o       <= '0;
        irq_level_o    <= '0;
        irq_priv_o     <= '0;
        irq_shv_o      <= 1'b0;
      end else if (kill_go) begin
        irq_kill_req_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clic_irq_tx.sv
// Bench for clic_irq_tx: directed scenarios plus randomized source vectors checked against
// a flat "highest level, lowest id" reference over all sources.
module tb_clic_irq_tx;
  localparam int N        = 256;
  localparam int L        = 16;
  localparam int W        = 8;
  localparam int IW       = 8;
  localparam int SCAN     = N / L;
  localparam int WAIT_MAX = 2 * SCAN + 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   ip, ie, shv;
  logic [N*W-1:0] lvl;
  logic [2*N-1:0] priv;
  logic [W-1:0]   thresh;
  logic           ready, kill_ack;
  logic           irq_valid, irq_shv, kill_req, claim;
  logic [IW-1:0]  irq_id, claim_id;
  logic [W-1:0]   irq_level;
  logic [1:0]     irq_priv;

  int errors = 0;
  int checks = 0;

  clic_irq_tx #(.NumSrc(N), .Lanes(L), .LvlW(W)) dut (
    .clk_i(clk), .rst_i(rst),
    .ip_i(ip), .ie_i(ie), .lvl_i(lvl), .priv_i(priv), .shv_i(shv), .thresh_i(thresh),
    .irq_valid_o(irq_valid), .irq_id_o(irq_id), .irq_level_o(irq_level),
    .irq_priv_o(irq_priv), .irq_shv_o(irq_shv), .irq_ready_i(ready),
    .irq_kill_req_o(kill_req), .irq_kill_ack_i(kill_ack),
    .claim_o(claim), .claim_id_o(claim_id)
  );

  always #5 clk = ~clk;

  // ---------------- clock / reset / drivers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_srcs;
    ip = '0; ie = '0; lvl = '0; priv = '0; shv = '0;
  endtask

  task automatic set_src(input int s, input int lv, input int pv, input int sv);
    ip[s] = 1'b1;
    ie[s] = 1'b1;
    lvl[s*W +: W] = W'(lv);
    priv[2*s +: 2] = 2'(pv);
    shv[s] = 1'(sv);
  endtask

  task automatic do_reset;
    rst = 1'b1; ready = 1'b0; kill_ack = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic wait_valid(output bit ok, output int n);
    ok = 1'b0; n = 0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      tick; n++;
      if (irq_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic accept_offer;
    ready = 1'b1; tick; ready = 1'b0;
  endtask

  // Reference: highest level among pending & enabled sources, lowest id on ties; id=-1 if none.
  function automatic void ref_best(output int id, output int lv);
    id = -1; lv = 0;
    for (int s = 0; s < N; s++)
      if (ip[s] && ie[s] && int'(lvl[s*W +: W]) > lv) begin
        id = s; lv = int'(lvl[s*W +: W]);
      end
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1; tick; tick;
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", irq_valid); end
    checks++; if (irq_id !== '0 || irq_level !== '0 || irq_priv !== '0 || irq_shv !== 1'b0) begin
      errors++; $display("FAIL reset_offer: got id=%0d lvl=%0d priv=%0d shv=%b want zeros", irq_id, irq_level, irq_priv, irq_shv); end
    checks++; if (kill_req !== 1'b0 || claim !== 1'b0 || claim_id !== '0) begin
      errors++; $display("FAIL reset_ctl: got kill=%b claim=%b cid=%0d want zeros", kill_req, claim, claim_id); end
  endtask

  task automatic test_basic;
    bit ok; int n;
    clear_srcs; thresh = '0;
    set_src(37, 5, 3, 1);
    do_reset;
    wait_valid(ok, n);
    checks++; if (!ok || n > 18) begin errors++; $display("FAIL basic_latency: got ok=%b cycles=%0d want valid within 18", ok, n); end
    checks++; if (irq_id !== 8'd37 || irq_level !== 8'd5) begin
      errors++; $display("FAIL basic_offer: got id=%0d lvl=%0d want 37/5", irq_id, irq_level); end
    checks++; if (irq_priv !== 2'd3 || irq_shv !== 1'b1) begin
      errors++; $display("FAIL basic_attr: got priv=%0d shv=%b want 3/1", irq_priv, irq_shv); end
    accept_offer;
    checks++; if (claim !== 1'b1 || claim_id !== 8'd37 || irq_valid !== 1'b0) begin
      errors++; $display("FAIL basic_claim: got claim=%b cid=%0d valid=%b want 1/37/0", claim, claim_id, irq_valid); end
    tick;
    checks++; if (claim !== 1'b0) begin errors++; $display("FAIL basic_claim_pulse: got %b want 0", claim); end
  endtask

  task automatic test_tie;
    bit ok; int n;
    clear_srcs; thresh = '0;
    set_src(10, 7, 1, 0);
    set_src(200, 7, 2, 1);
    do_reset;
    wait_valid(ok, n);
    checks++; if (!ok || irq_id !== 8'd10 || irq_level !== 8'd7) begin
      errors++; $display("FAIL tie_low_id: got ok=%b id=%0d lvl=%0d want 10/7", ok, irq_id, irq_level); end
    accept_offer;
    set_src(200, 9, 2, 1);
    wait_valid(ok, n);
    checks++; if (!ok || irq_id !== 8'd200 || irq_level !== 8'd9) begin
      errors++; $display("FAIL tie_higher: got ok=%b id=%0d lvl=%0d want 200/9", ok, irq_id, irq_level); end
    accept_offer;
  endtask

  task automatic test_threshold;
    bit ok, seen; int n;
    clear_srcs; thresh = 8'd7;
    set_src(5, 7, 0, 0);
    do_reset;
    seen = 1'b0;
    repeat (100) begin tick; if (irq_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL thresh_block: got valid=%b want 0", seen); end
    thresh = 8'd6;
    wait_valid(ok, n);
    checks++; if (!ok || irq_id !== 8'd5) begin
      errors++; $display("FAIL thresh_pass: got ok=%b id=%0d want 5", ok, irq_id); end
    accept_offer;
    thresh = '0;
  endtask

  task automatic test_kill;
    bit ok, seen_claim; int n;
    clear_srcs; thresh = '0;
    set_src(37, 5, 0, 0);
    do_reset;
    wait_valid(ok, n);
    checks++; if (!ok || irq_id !== 8'd37) begin errors++; $display("FAIL kill_offer: got ok=%b id=%0d want 37", ok, irq_id); end
    ip[37] = 1'b0;
    seen_claim = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      if (claim) seen_claim = 1'b1;
      checks++; if (kill_req !== 1'b1 || irq_valid !== 1'b1 || irq_id !== 8'd37) begin
        errors++; $display("FAIL kill_hold: cycle %0d got kill=%b valid=%b id=%0d want 1/1/37", c, kill_req, irq_valid, irq_id); end
    end
    kill_ack = 1'b1; tick; kill_ack = 1'b0;
    if (claim) seen_claim = 1'b1;
    checks++; if (kill_req !== 1'b0 || irq_valid !== 1'b0 || seen_claim !== 1'b0) begin
      errors++; $display("FAIL kill_done: got kill=%b valid=%b claim_seen=%b want 0/0/0", kill_req, irq_valid, seen_claim); end
  endtask

  task automatic test_preempt;
    bit ok; int n;
    clear_srcs; thresh = '0;
    set_src(37, 5, 0, 0);
    do_reset;
    wait_valid(ok, n);
    checks++; if (!ok || irq_id !== 8'd37) begin errors++; $display("FAIL pre_offer: got ok=%b id=%0d want 37", ok, irq_id); end
    set_src(50, 9, 1, 1);
`ifdef CLIC_IRQ_TX_PREEMPT_EN
    ok = 1'b0;
    for (int i = 0; i < WAIT_MAX; i++) begin tick; if (kill_req) begin ok = 1'b1; break; end end
    checks++; if (!ok || irq_id !== 8'd37) begin errors++; $display("FAIL pre_kill: got kill=%b id=%0d want 1/37", ok, irq_id); end
    kill_ack = 1'b1; tick; kill_ack = 1'b0;
    checks++; if (irq_valid !== 1'b0 || claim !== 1'b0) begin
      errors++; $display("FAIL pre_drop: got valid=%b claim=%b want 0/0", irq_valid, claim); end
    wait_valid(ok, n);
    checks++; if (!ok || irq_id !== 8'd50 || irq_level !== 8'd9) begin
      errors++; $display("FAIL pre_reoffer: got ok=%b id=%0d lvl=%0d want 50/9", ok, irq_id, irq_level); end
    accept_offer;
`else
    begin
      bit seen_kill, moved;
      seen_kill = 1'b0; moved = 1'b0;
      repeat (WAIT_MAX + 4) begin
        tick;
        if (kill_req) seen_kill = 1'b1;
        if (!irq_valid || irq_id !== 8'd37) moved = 1'b1;
      end
      checks++; if (seen_kill !== 1'b0 || moved !== 1'b0) begin
        errors++; $display("FAIL nopre_hold: got kill_seen=%b changed=%b want 0/0", seen_kill, moved); end
      accept_offer;
      checks++; if (claim !== 1'b1 || claim_id !== 8'd37) begin
        errors++; $display("FAIL nopre_claim: got claim=%b cid=%0d want 1/37", claim, claim_id); end
    end
`endif
  endtask

  task automatic test_back_to_back;
    bit ok; int n;
    clear_srcs; thresh = '0;
    set_src(37, 5, 0, 0);
    do_reset;
    wait_valid(ok, n);
    ip[37] = 1'b0;
    tick;
    checks++; if (!ok || kill_req !== 1'b1) begin errors++; $display("FAIL b2b_kill: got ok=%b kill=%b want 1/1", ok, kill_req); end
    ready = 1'b1; kill_ack = 1'b1; tick; ready = 1'b0; kill_ack = 1'b0;
    checks++; if (claim !== 1'b1 || claim_id !== 8'd37 || kill_req !== 1'b0 || irq_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_accept_wins: got claim=%b cid=%0d kill=%b valid=%b want 1/37/0/0", claim, claim_id, kill_req, irq_valid); end
    ip[37] = 1'b1;
    wait_valid(ok, n);
    #2 rst = 1'b1;
    #1;
    checks++; if (!ok || irq_valid !== 1'b0 || kill_req !== 1'b0 || claim !== 1'b0 || irq_id !== '0) begin
      errors++; $display("FAIL async_reset: got ok=%b valid=%b kill=%b claim=%b id=%0d want 1/0/0/0/0", ok, irq_valid, kill_req, claim, irq_id); end
    tick;
    checks++; if (claim !== 1'b0) begin errors++; $display("FAIL async_reset_claim: got %b want 0", claim); end
    rst = 1'b0;
  endtask

  task automatic test_random;
    bit ok, seen; int n, eid, elv, k, s, lv0, lv;
    for (int it = 0; it < 10; it++) begin
      clear_srcs;
      thresh = W'($urandom_range(0, 4));
      k = $urandom_range(1, 6);
      lv0 = 0;
      for (int j = 0; j < k; j++) begin
        s = $urandom_range(0, N - 1);
        if (j == 1 && $urandom_range(0, 1) == 1) lv = lv0;
        else if ($urandom_range(0, 3) == 0) lv = $urandom_range(0, 3);
        else lv = $urandom_range(0, 255);
        if (j == 0) lv0 = lv;
        set_src(s, lv, $urandom_range(0, 3), $urandom_range(0, 1));
        if ($urandom_range(0, 4) == 0) ie[s] = 1'b0;
      end
      ref_best(eid, elv);
      do_reset;
      if (eid >= 0 && elv > int'(thresh)) begin
        wait_valid(ok, n);
        checks++; if (!ok || irq_id !== IW'(eid) || irq_level !== W'(elv)) begin
          errors++; $display("FAIL rand_offer[%0d]: got ok=%b id=%0d lvl=%0d want %0d/%0d", it, ok, irq_id, irq_level, eid, elv); end
        checks++; if (irq_priv !== priv[2*eid +: 2] || irq_shv !== shv[eid]) begin
          errors++; $display("FAIL rand_attr[%0d]: got priv=%0d shv=%b want %0d/%b", it, irq_priv, irq_shv, priv[2*eid +: 2], shv[eid]); end
        accept_offer;
        checks++; if (claim !== 1'b1 || claim_id !== IW'(eid)) begin
          errors++; $display("FAIL rand_claim[%0d]: got claim=%b cid=%0d want 1/%0d", it, claim, claim_id, eid); end
      end else begin
        seen = 1'b0;
        repeat (WAIT_MAX) begin tick; if (irq_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin
          errors++; $display("FAIL rand_none[%0d]: got valid=%b want 0 (best lvl %0d thresh %0d)", it, seen, elv, thresh); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_srcs; thresh = '0; ready = 1'b0; kill_ack = 1'b0;
    test_reset;
    test_basic;
    test_tie;
    test_threshold;
    test_kill;
    test_preempt;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
